controller_sequencer: RTL

SAP-1 controller-sequencer. It steps a one-hot six-state ring counter (T1–T6) and decodes the instruction-register opcode. From these it drives the 12-bit control word that the program counter, MAR, RAM, IR, accumulator, ALU, B register and output register consume. It sits directly upstream of the program counter and supplies its `Cp` and `Ep` strobes. It also provides run/single-step control and HLT handling.

---
 rtl/controller_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1-T6 ring counter, opcode decode,
// run/single-step control and halt handling. Drives the 12-bit control word.
module controller_sequencer #(
    parameter bit EARLY_END = 1'b0
) (
    input  logic       CLK_bar,
    input  logic       CLR,
    input  logic       RUN,
    input  logic       STEP,
    input  logic [3:0] IR_op,
    output logic [5:0] T,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_bar,
    output logic       CE_bar,
    output logic       Li_bar,
    output logic       Ei_bar,
    output logic       La_bar,
    output logic       Lb_bar,
    output logic       Lo_bar,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       HLT
);

    localparam logic [5:0] T1_ST = 6'b000001;
    localparam logic [5:0] T2_ST = 6'b000010;
    localparam logic [5:0] T3_ST = 6'b000100;
    localparam logic [5:0] T4_ST = 6'b001000;
    localparam logic [5:0] T5_ST = 6'b010000;
    localparam logic [5:0] T6_ST = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [5:0] t_q;
    logic [5:0] t_next;
    logic       halted;
    logic       halted_next;
    logic       step_d;
    logic       adv;
    logic       en_ok;
    logic       op_lda;
    logic       op_add;
    logic       op_sub;
    logic       op_out;
    logic       op_hlt;
    logic       op_undef;

    // Raw (ungated, active-high) control word from state decode
    logic cp_w, ep_w, lm_w, ce_w, li_w, ei_w, la_w, lb_w, lo_w, ea_w, su_w, eu_w;

    assign op_lda   = (IR_op == OP_LDA);
    assign op_add   = (IR_op == OP_ADD);
    assign op_sub   = (IR_op == OP_SUB);
    assign op_out   = (IR_op == OP_OUT);
    assign op_hlt   = (IR_op == OP_HLT);
    assign op_undef = ~(op_lda | op_add | op_sub | op_out | op_hlt);

    // Single-step advances only on a sampled 0->1 of STEP
    assign adv   = ~CLR & ~halted & (RUN | (STEP & ~step_d));
    assign en_ok = ~CLR & ~halted;

    // Next T-state and halt detection
    always_comb begin
        t_next      = t_q;
        halted_next = halted;
        if (adv) begin
            if ((t_q == T4_ST) && op_hlt) begin
                halted_next = 1'b1;
            end else begin
                case (t_q)
                    T1_ST:   t_next = T2_ST;
                    T2_ST:   t_next = T3_ST;
                    T3_ST:   t_next = (EARLY_END && op_undef) ? T1_ST : T4_ST;
                    T4_ST:   t_next = (EARLY_END && op_out) ? T1_ST : T5_ST;
                    T5_ST:   t_next = (EARLY_END && op_lda) ? T1_ST : T6_ST;
                    T6_ST:   t_next = T1_ST;
                    // Recover from any non-one-hot value
                    default: t_next = T1_ST;
                endcase
            end
        end
    end

    // State registers with synchronous clear
    always_ff @(posedge CLK_bar) begin
        if (CLR) begin
            t_q    <= T1_ST;
            halted <= 1'b0;
            step_d <= 1'b0;
        end else begin
            t_q    <= t_next;
            halted <= halted_next;
            step_d <= STEP;
        end
    end

    // Control word decode from T-state and opcode
    always_comb begin
        cp_w = 1'b0;
        ep_w = 1'b0;
        lm_w = 1'b0;
        ce_w = 1'b0;
        li_w = 1'b0;
        ei_w = 1'b0;
        la_w = 1'b0;
        lb_w = 1'b0;
        lo_w = 1'b0;
        ea_w = 1'b0;
        su_w = 1'b0;
        eu_w = 1'b0;
        case (t_q)
            T1_ST: begin
                ep_w = 1'b1;
                lm_w = 1'b1;
            end
            T2_ST: begin
                cp_w = 1'b1;
            end
            T3_ST: begin
                ce_w = 1'b1;
                li_w = 1'b1;
            end
            T4_ST: begin
                if (op_lda | op_add | op_sub) begin
                    ei_w = 1'b1;
                    lm_w = 1'b1;
                end else if (op_out) begin
                    ea_w = 1'b1;
                    lo_w = 1'b1;
                end
            end
            T5_ST: begin
                if (op_lda) begin
                    ce_w = 1'b1;
                    la_w = 1'b1;
                end else if (op_add | op_sub) begin
                    ce_w = 1'b1;
                    lb_w = 1'b1;
                end
            end
            T6_ST: begin
                if (op_add | op_sub) begin
                    su_w = op_sub;
                    eu_w = 1'b1;
                    la_w = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Load strobes only fire on an advancing cycle; bus enables follow state
    assign Cp     = cp_w & adv;
    assign Lm_bar = ~(lm_w & adv);
    assign Li_bar = ~(li_w & adv);
    assign La_bar = ~(la_w & adv);
    assign Lb_bar = ~(lb_w & adv);
    assign Lo_bar = ~(lo_w & adv);
    assign Ep     = ep_w & en_ok;
    assign CE_bar = ~(ce_w & en_ok);
    assign Ei_bar = ~(ei_w & en_ok);
    assign Ea     = ea_w & en_ok;
    assign Su     = su_w & en_ok;
    assign Eu     = eu_w & en_ok;

    assign T   = t_q;
    assign HLT = halted;

endmodule
